sdram_bist_7seg: RTL



---
 rtl/sdram_bist_7seg_if.sv | 25 ++
 rtl/sdram_bist_7seg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bist_7seg_if.sv
// Avalon-MM bus between the BIST master and the SDRAM controller slave port.
interface sdram_bist_7seg_if #(
  parameter int unsigned ADDR_W = 25,
  parameter int unsigned DATA_W = 16
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable_n;
  logic                chipselect;
  logic                read_n;
  logic                write_n;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable_n, chipselect, read_n, write_n, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable_n, chipselect, read_n, write_n, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/sdram_bist_7seg.sv
// SDRAM write/read-back checker: writes a pattern block, reads it back,
// counts mismatches/timeouts and shows the progress/result on a scanned
// hex 7-segment display.
module sdram_bist_7seg #(
  parameter int unsigned       ADDR_W         = 25,
  parameter int unsigned       DATA_W         = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = 25'h000100,
  parameter int unsigned       NUM_WORDS      = 16,
  parameter logic [15:0]       SEED           = 16'hA5C3,
  parameter int unsigned       NUM_DIGITS     = 4,
  parameter int unsigned       REFRESH_DIV    = 50000,
  parameter int unsigned       TIMEOUT_CYC    = 1024,
  parameter bit                SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  start,
  sdram_bist_7seg_if.master     avm,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  localparam int unsigned IDX_W  = (NUM_WORDS   > 1) ? $clog2(NUM_WORDS)   : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DIG_W  = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
  localparam int unsigned DISP_W = 4 * NUM_DIGITS;

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   tcnt;
  logic [15:0]       err_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              cs_q;
  logic              read_n_q;
  logic              write_n_q;

  logic [REF_W-1:0]      ref_cnt;
  logic [DIG_W-1:0]      dig_cnt;
  logic [DISP_W-1:0]     disp_val;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] sel_onehot;

  logic        idx_last;
  logic        word_bad;
  logic        timed_out;
  logic [15:0] err_next;

  function automatic logic [DATA_W-1:0] pat(input logic [IDX_W-1:0] i);
    return DATA_W'(SEED) + DATA_W'(i) * DATA_W'(16'h0101);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_W'(i);
  endfunction

  // Active-high {a..g} hex glyphs.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    unique case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  assign avm.address      = addr_q;
  assign avm.writedata    = wdata_q;
  assign avm.chipselect   = cs_q;
  assign avm.read_n       = read_n_q;
  assign avm.write_n      = write_n_q;
  assign avm.byteenable_n = '0;

  // Per-word read-back verdict and saturating error increment.
  always_comb begin
    idx_last  = (idx == IDX_W'(NUM_WORDS - 1));
    timed_out = (tcnt == TO_W'(TIMEOUT_CYC - 1));
    word_bad  = avm.readdatavalid ? (avm.readdata != pat(idx)) : 1'b1;
    err_next  = (err_cnt == '1) ? err_cnt : err_cnt + 16'd1;
  end

  // Pass sequencer: bus request registers are loaded one cycle ahead so the
  // next write/read is already on the bus the cycle after acceptance.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      tcnt      <= '0;
      err_cnt   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cs_q      <= 1'b0;
      read_n_q  <= 1'b1;
      write_n_q <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= '0;
            err_cnt   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            cs_q      <= 1'b1;
            write_n_q <= 1'b0;
            addr_q    <= addr_of('0);
            wdata_q   <= pat('0);
            state     <= WR;
          end
        end
        WR: begin
          if (!avm.waitrequest) begin
            if (idx_last) begin
              idx       <= '0;
              write_n_q <= 1'b1;
              read_n_q  <= 1'b0;
              addr_q    <= addr_of('0);
              state     <= RD_REQ;
            end else begin
              idx     <= idx + 1'b1;
              addr_q  <= addr_of(idx + 1'b1);
              wdata_q <= pat(idx + 1'b1);
            end
          end
        end
        RD_REQ: begin
          if (!avm.waitrequest) begin
            cs_q     <= 1'b0;
            read_n_q <= 1'b1;
            tcnt     <= '0;
            state    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (avm.readdatavalid || timed_out) begin
            if (word_bad) err_cnt <= err_next;
            if (idx_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !word_bad && (err_cnt == '0);
              state <= DONE;
            end else begin
              idx      <= idx + 1'b1;
              cs_q     <= 1'b1;
              read_n_q <= 1'b0;
              addr_q   <= addr_of(idx + 1'b1);
              state    <= RD_REQ;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Value on display and the nibble/digit currently being scanned.
  always_comb begin
    if (busy)      disp_val = DISP_W'(idx);
    else if (done) disp_val = DISP_W'(err_cnt);
    else           disp_val = '0;
    nibble     = 4'(disp_val >> {dig_cnt, 2'b00});
    sel_onehot = NUM_DIGITS'(1) << dig_cnt;
  end

  // Digit scan timing and registered segment/digit drive.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ref_cnt   <= '0;
      dig_cnt   <= '0;
      seg       <= SEG_ACTIVE_LOW ? '1 : '0;
      digit_sel <= SEG_ACTIVE_LOW ? '1 : '0;
    end else begin
      if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        dig_cnt <= (dig_cnt == DIG_W'(NUM_DIGITS - 1)) ? '0 : dig_cnt + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      seg       <= SEG_ACTIVE_LOW ? ~glyph(nibble) : glyph(nibble);
      digit_sel <= SEG_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
    end
  end

endmodule
